// File: rtl/result_packer_pkg.sv
// Shared widths and helpers for the coding unit and its neighbours.
package result_packer_pkg;

    localparam int unsigned BYTE = 8;
    localparam int unsigned WORD = 32;

    // Width of a lane counter able to hold 0..pack.
    function automatic int unsigned cnt_width(input int unsigned pack);
        return $clog2(pack + 1);
    endfunction

    // Width of a packed word made of pack results of data_w bits.
    function automatic int unsigned packed_width(input int unsigned data_w, input int unsigned pack);
        return data_w * pack;
    endfunction

endpackage

// File: rtl/result_packer_if.sv
// Result input, flush method and packed-word output of the result packer.
interface result_packer_if
    import result_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WORD,
    parameter int unsigned PACK       = 4
);
    localparam int unsigned CNT_W = cnt_width(PACK);
    localparam int unsigned PW    = packed_width(DATA_WIDTH, PACK);

    logic                  res_rdy_i;
    logic [DATA_WIDTH-1:0] res_data_i;
    logic                  res_en_o;
    logic                  flush_en_i;
    logic                  flush_rdy_o;
    logic                  out_en_i;
    logic                  out_rdy_o;
    logic [PW-1:0]         out_data_o;
    logic [CNT_W-1:0]      out_cnt_o;

    // Environment side: upstream producer, flush requester and downstream consumer.
    modport master (
        output res_rdy_i, res_data_i, flush_en_i, out_en_i,
        input  res_en_o, flush_rdy_o, out_rdy_o, out_data_o, out_cnt_o
    );

    // Packer side.
    modport slave (
        input  res_rdy_i, res_data_i, flush_en_i, out_en_i,
        output res_en_o, flush_rdy_o, out_rdy_o, out_data_o, out_cnt_o
    );
endinterface

// File: rtl/result_packer_fifo.sv
// Generic synchronous FIFO; head shows the oldest entry, stale when empty.
module result_packer_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (occ == OCC_W'(DEPTH));
    assign empty   = (occ == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; simultaneous push and pop keep occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push && !do_pop) begin
                occ <= occ + OCC_W'(1);
            end else if (do_pop && !do_push) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end
endmodule

// File: rtl/result_packer.sv
// Drains results from the coding unit, packs PACK of them per word and queues the words.
module result_packer
    import result_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WORD,
    parameter int unsigned PACK       = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    result_packer_if.slave  io
);
    localparam int unsigned CNT_W = cnt_width(PACK);
    localparam int unsigned IDX_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned PW    = packed_width(DATA_WIDTH, PACK);

    logic [IDX_W-1:0]                 idx;
    logic [PACK-1:0][DATA_WIDTH-1:0]  lanes;
    logic [PACK-1:0][DATA_WIDTH-1:0]  word_lanes;
    logic [CNT_W-1:0]                 push_cnt;
    logic [PW+CNT_W-1:0]              fifo_head;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic                             last;
    logic                             res_en;
    logic                             flush_rdy;
    logic                             flush_fire;
    logic                             push;

    // Handshake glue: the completing capture and the flush both need a free FIFO slot.
    assign last       = (idx == IDX_W'(PACK - 1));
    assign res_en     = io.res_rdy_i & ~rst_i & ~(last & fifo_full);
    assign flush_rdy  = (idx != '0) & ~fifo_full;
    assign flush_fire = io.flush_en_i & flush_rdy;
    assign push       = (res_en & last) | flush_fire;

    assign io.res_en_o    = res_en;
    assign io.flush_rdy_o = flush_rdy;
    assign io.out_rdy_o   = ~fifo_empty;
    assign io.out_data_o  = fifo_head[PW-1:0];
    assign io.out_cnt_o   = fifo_head[PW +: CNT_W];

    // Word being pushed: current lanes plus any same-cycle datum, counting it first.
    always_comb begin
        word_lanes = lanes;
        if (res_en) begin
            word_lanes[idx] = io.res_data_i;
        end
        push_cnt = CNT_W'(idx) + CNT_W'(res_en);
    end

    // Lane registers and lane index; a push restarts an empty word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx   <= '0;
            lanes <= '0;
        end else if (push) begin
            idx   <= '0;
            lanes <= '0;
        end else if (res_en) begin
            lanes[idx] <= io.res_data_i;
            idx        <= idx + IDX_W'(1);
        end
    end

    result_packer_fifo #(
        .WIDTH (PW + CNT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (io.out_en_i),
        .wdata ({push_cnt, word_lanes}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer (PACK=4, DATA_WIDTH=32, FIFO_DEPTH=2).
module tb_result_packer;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    result_packer_if #(.DATA_WIDTH(32), .PACK(4)) bus ();

    result_packer #(
        .DATA_WIDTH (32),
        .PACK       (4),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Capture one result this cycle (res_en expected high).
    task automatic cap(input logic [31:0] d, input string tag);
        bus.res_rdy_i  = 1'b1;
        bus.res_data_i = d;
        #1;
        check(tag, 128'(bus.res_en_o), 128'd1);
        cyc();
        bus.res_rdy_i = 1'b0;
    endtask

    // Pop the head word.
    task automatic pop();
        bus.out_en_i = 1'b1;
        cyc();
        bus.out_en_i = 1'b0;
    endtask

    // Method enables must only be raised while the matching rdy is high.
    always @(posedge clk) begin
        if (!rst && bus.flush_en_i) check("proto_flush", 128'(bus.flush_rdy_o), 128'd1);
        if (!rst && bus.out_en_i)   check("proto_out", 128'(bus.out_rdy_o), 128'd1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.res_rdy_i  = 1'b0;
        bus.res_data_i = '0;
        bus.flush_en_i = 1'b0;
        bus.out_en_i   = 1'b0;
        #2;
        check("rst_res_en", 128'(bus.res_en_o), 128'd0);
        check("rst_out_rdy", 128'(bus.out_rdy_o), 128'd0);
        check("rst_flush_rdy", 128'(bus.flush_rdy_o), 128'd0);
        check("rst_out_data", 128'(bus.out_data_o), 128'd0);
        check("rst_out_cnt", 128'(bus.out_cnt_o), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc();

        // 1: four back-to-back results form one full word
        cap(32'h11, "t1_en0");
        cap(32'h22, "t1_en1");
        cap(32'h33, "t1_en2");
        check("t1_not_rdy", 128'(bus.out_rdy_o), 128'd0);
        cap(32'h44, "t1_en3");
        check("t1_out_rdy", 128'(bus.out_rdy_o), 128'd1);
        check("t1_data", 128'(bus.out_data_o), 128'h00000044_00000033_00000022_00000011);
        check("t1_cnt", 128'(bus.out_cnt_o), 128'd4);
        pop();
        check("t1_empty", 128'(bus.out_rdy_o), 128'd0);

        // 2: back-pressure with a full FIFO stalls the completing capture
        for (int k = 1; k <= 11; k++) begin
            cap(32'(k), "t2_en");
        end
        bus.res_rdy_i  = 1'b1;
        bus.res_data_i = 32'd12;
        #1;
        check("t2_stall", 128'(bus.res_en_o), 128'd0);
        check("t2_flush_full", 128'(bus.flush_rdy_o), 128'd0);
        check("t2_head0", 128'(bus.out_data_o), 128'h00000004_00000003_00000002_00000001);
        bus.out_en_i = 1'b1;
        cyc();
        bus.out_en_i = 1'b0;
        #1;
        check("t2_resume", 128'(bus.res_en_o), 128'd1);
        check("t2_head1", 128'(bus.out_data_o), 128'h00000008_00000007_00000006_00000005);
        cyc();
        bus.res_rdy_i = 1'b0;
        pop();
        check("t2_head2", 128'(bus.out_data_o), 128'h0000000c_0000000b_0000000a_00000009);
        check("t2_cnt2", 128'(bus.out_cnt_o), 128'd4);
        pop();
        check("t2_empty", 128'(bus.out_rdy_o), 128'd0);

        // 3: flush of a two-lane partial word
        check("t3_flush_idx0", 128'(bus.flush_rdy_o), 128'd0);
        cap(32'hA, "t3_en0");
        check("t3_flush_rdy", 128'(bus.flush_rdy_o), 128'd1);
        cap(32'hB, "t3_en1");
        bus.flush_en_i = 1'b1;
        cyc();
        bus.flush_en_i = 1'b0;
        #1;
        check("t3_data", 128'(bus.out_data_o), 128'h00000000_00000000_0000000b_0000000a);
        check("t3_cnt", 128'(bus.out_cnt_o), 128'd2);
        check("t3_flush_after", 128'(bus.flush_rdy_o), 128'd0);
        pop();

        // 4: flush and last capture together give one full word, no empty extra
        cap(32'hA, "t4_en0");
        cap(32'hB, "t4_en1");
        cap(32'hC, "t4_en2");
        bus.res_rdy_i  = 1'b1;
        bus.res_data_i = 32'hD;
        bus.flush_en_i = 1'b1;
        cyc();
        bus.res_rdy_i  = 1'b0;
        bus.flush_en_i = 1'b0;
        #1;
        check("t4_cnt", 128'(bus.out_cnt_o), 128'd4);
        check("t4_data", 128'(bus.out_data_o), 128'h0000000d_0000000c_0000000b_0000000a);
        check("t4_flush_idx0", 128'(bus.flush_rdy_o), 128'd0);
        pop();
        check("t4_no_extra", 128'(bus.out_rdy_o), 128'd0);

        // 5: asynchronous reset mid-word with a queued word
        cap(32'h41, "t5_pre0");
        cap(32'h42, "t5_pre1");
        cap(32'h43, "t5_pre2");
        cap(32'h44, "t5_pre3");
        cap(32'h51, "t5_en0");
        cap(32'h52, "t5_en1");
        bus.res_rdy_i  = 1'b1;
        bus.res_data_i = 32'h53;
        #1;
        check("t5_en_pre", 128'(bus.res_en_o), 128'd1);
        rst = 1'b1;
        #1;
        check("t5_en_drop", 128'(bus.res_en_o), 128'd0);
        check("t5_rdy_drop", 128'(bus.out_rdy_o), 128'd0);
        check("t5_data_clr", 128'(bus.out_data_o), 128'd0);
        bus.res_rdy_i  = 1'b0;
        rst = 1'b0;
        cyc();
        cap(32'h61, "t5_post0");
        cap(32'h62, "t5_post1");
        cap(32'h63, "t5_post2");
        cap(32'h64, "t5_post3");
        check("t5_data", 128'(bus.out_data_o), 128'h00000064_00000063_00000062_00000061);
        check("t5_cnt", 128'(bus.out_cnt_o), 128'd4);
        pop();
        check("t5_single", 128'(bus.out_rdy_o), 128'd0);

        // 6: push and pop in the same cycle keep the FIFO non-empty
        for (int k = 0; k < 4; k++) begin
            cap(32'h71 + 32'(k), "t6_w0");
        end
        for (int k = 0; k < 3; k++) begin
            cap(32'h81 + 32'(k), "t6_w1");
        end
        bus.res_rdy_i  = 1'b1;
        bus.res_data_i = 32'h84;
        bus.out_en_i   = 1'b1;
        cyc();
        bus.res_rdy_i = 1'b0;
        bus.out_en_i  = 1'b0;
        #1;
        check("t6_rdy", 128'(bus.out_rdy_o), 128'd1);
        check("t6_head", 128'(bus.out_data_o), 128'h00000084_00000083_00000082_00000081);
        pop();
        check("t6_empty", 128'(bus.out_rdy_o), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
